// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one MEM-stage memory op, checks its
// alignment, runs a single big-endian bus transfer with a wait timeout, and
// returns the extended load result or an exception code.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   op_valid_i, op_i, addr_i,       memory op from the MEM stage
//   wdata_i, flush_i                store data, pipeline flush
//   bus_req_o, bus_we_o, bus_addr_o,
//   bus_sel_o, bus_wdata_o          registered bus request
//   bus_ack_i, bus_err_i,
//   bus_rdata_i                     bus response
//   stall_o, done_o                 pipeline hold, one-cycle completion pulse
//   rdata_o, exc_o, exc_code_o      result, valid with done_o
module lsu_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid_i,
   input  logic [2:0]        op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic              flush_i,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_sel_o,
   output logic [31:0]       bus_wdata_o,
   input  logic              bus_ack_i,
   input  logic              bus_err_i,
   input  logic [31:0]       bus_rdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [31:0]       rdata_o,
   output logic              exc_o,
   output logic [4:0]        exc_code_o
);

   localparam int unsigned CNT_W = 8;
   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LBU = 3'd1;
   localparam logic [2:0] OP_LH  = 3'd2;
   localparam logic [2:0] OP_LHU = 3'd3;
   localparam logic [2:0] OP_LW  = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;
   localparam logic [4:0] EXC_LOAD_ALIGN  = 5'd4;
   localparam logic [4:0] EXC_STORE_ALIGN = 5'd5;
   localparam logic [4:0] EXC_BUS         = 5'd7;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q;
   logic [1:0]         off_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               abort_q;
   logic               bus_req_q, bus_we_q;
   logic [ADDR_W-1:0]  bus_addr_q;
   logic [3:0]         bus_sel_q;
   logic [31:0]        bus_wdata_q;
   logic [31:0]        rdata_q;
   logic               exc_q;
   logic [4:0]         code_q;

   logic               accept, resolve, timeout_c, store_c, misalign_c;
   logic [3:0]         sel_c;
   logic [31:0]        wdata_c;
   logic [7:0]         byte_c;
   logic [15:0]        half_c;
   logic [31:0]        load_c;

   // Lane select, store replication and alignment check for the incoming op
   always_comb begin
      sel_c      = 4'b0000;
      wdata_c    = 32'd0;
      misalign_c = 1'b0;
      case (op_i)
         OP_LB, OP_LBU, OP_SB: begin
            sel_c   = 4'b1000 >> addr_i[1:0];
            wdata_c = {4{wdata_i[7:0]}};
         end
         OP_LH, OP_LHU, OP_SH: begin
            misalign_c = addr_i[0];
            sel_c      = addr_i[1] ? 4'b0011 : 4'b1100;
            wdata_c    = {2{wdata_i[15:0]}};
         end
         default: begin
            misalign_c = |addr_i[1:0];
            sel_c      = 4'b1111;
            wdata_c    = wdata_i;
         end
      endcase
   end

   assign store_c   = (op_i == OP_SB) || (op_i == OP_SH) || (op_i == OP_SW);
   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Load extraction from the big-endian lane(s) of the latched offset
   always_comb begin
      case (off_q)
         2'd0:    byte_c = bus_rdata_i[31:24];
         2'd1:    byte_c = bus_rdata_i[23:16];
         2'd2:    byte_c = bus_rdata_i[15:8];
         default: byte_c = bus_rdata_i[7:0];
      endcase
      half_c = off_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
      case (op_q)
         OP_LB:   load_c = {{24{byte_c[7]}}, byte_c};
         OP_LBU:  load_c = {24'd0, byte_c};
         OP_LH:   load_c = {{16{half_c[15]}}, half_c};
         OP_LHU:  load_c = {16'd0, half_c};
         OP_LW:   load_c = bus_rdata_i;
         default: load_c = 32'd0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state; an aborted op drains the bus and returns straight to IDLE
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      resolve = 1'b0;
      case (state_q)
         IDLE: begin
            if (op_valid_i && !flush_i) begin
               accept  = 1'b1;
               state_d = misalign_c ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (bus_err_i || bus_ack_i || timeout_c) begin
               resolve = 1'b1;
               state_d = (abort_q || flush_i) ? IDLE : DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Op latch, bus request registers, wait counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q        <= 3'd0;
         off_q       <= 2'd0;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_sel_q   <= 4'd0;
         bus_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         exc_q       <= 1'b0;
         code_q      <= 5'd0;
      end else begin
         if (accept) begin
            op_q    <= op_i;
            off_q   <= addr_i[1:0];
            cnt_q   <= '0;
            abort_q <= 1'b0;
            if (misalign_c) begin
               exc_q  <= 1'b1;
               code_q <= store_c ? EXC_STORE_ALIGN : EXC_LOAD_ALIGN;
            end else begin
               bus_req_q   <= 1'b1;
               bus_we_q    <= store_c;
               bus_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
               bus_sel_q   <= sel_c;
               bus_wdata_q <= wdata_c;
            end
         end
         if (state_q == BUSY) begin
            if (flush_i) abort_q <= 1'b1;
            if (resolve) begin
               bus_req_q   <= 1'b0;
               bus_we_q    <= 1'b0;
               bus_addr_q  <= '0;
               bus_sel_q   <= 4'd0;
               bus_wdata_q <= 32'd0;
               abort_q     <= 1'b0;
               cnt_q       <= '0;
               if (!(abort_q || flush_i)) begin
                  // error wins over a simultaneous ack; no ack here means timeout
                  if (bus_err_i || !bus_ack_i) begin
                     exc_q  <= 1'b1;
                     code_q <= EXC_BUS;
                  end else begin
                     rdata_q <= load_c;
                  end
               end
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         if (state_q == DONE) begin
            rdata_q <= 32'd0;
            exc_q   <= 1'b0;
            code_q  <= 5'd0;
         end
      end
   end

   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_sel_o   = bus_sel_q;
   assign bus_wdata_o = bus_wdata_q;
   assign rdata_o     = rdata_q;
   assign exc_o       = exc_q;
   assign exc_code_o  = code_q;

   // Stall must react in the same cycle an op arrives
   assign stall_o = ((state_q == IDLE) && op_valid_i && !flush_i) || (state_q == BUSY);
   assign done_o  = (state_q == DONE) && !flush_i;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

   typedef struct {
      logic [31:0] rdata;
      logic        exc;
      logic [4:0]  code;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid_i;
   logic [2:0]  op_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        flush_i;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i, bus_err_i;
   logic [31:0] bus_rdata_i;
   logic        stall_o, done_o;
   logic [31:0] rdata_o;
   logic        exc_o;
   logic [4:0]  exc_code_o;

   int   checks = 0;
   int   failures = 0;
   int   done_seen = 0;
   exp_t sb[$];
   exp_t mon_e;

   lsu_ctrl #(.ADDR_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .op_valid_i(op_valid_i), .op_i(op_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .flush_i(flush_i),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
      .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i),
      .stall_o(stall_o), .done_o(done_o),
      .rdata_o(rdata_o), .exc_o(exc_o), .exc_code_o(exc_code_o)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] r, input logic x, input logic [4:0] c);
      exp_t e;
      e.rdata = r;
      e.exc   = x;
      e.code  = c;
      return e;
   endfunction

   function automatic logic f_store(input logic [2:0] op);
      return op >= 3'd5;
   endfunction

   function automatic logic f_misalign(input logic [2:0] op, input logic [1:0] off);
      if (op == 3'd2 || op == 3'd3 || op == 3'd6) return off[0];
      if (op == 3'd4 || op == 3'd7) return off != 2'd0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] f_sel(input logic [2:0] op, input logic [1:0] off);
      if (op == 3'd0 || op == 3'd1 || op == 3'd5) begin
         case (off)
            2'd0: return 4'b1000;
            2'd1: return 4'b0100;
            2'd2: return 4'b0010;
            default: return 4'b0001;
         endcase
      end
      if (op == 3'd2 || op == 3'd3 || op == 3'd6) return off[1] ? 4'b0011 : 4'b1100;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] f_wdata(input logic [2:0] op, input logic [31:0] w);
      if (op == 3'd5) return {w[7:0], w[7:0], w[7:0], w[7:0]};
      if (op == 3'd6) return {w[15:0], w[15:0]};
      return w;
   endfunction

   function automatic logic [31:0] f_load(input logic [2:0] op, input logic [1:0] off, input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * (3 - int'(off)))) & 32'h0000_00FF;
      h = (rd >> (8 * (2 - int'(off)))) & 32'h0000_FFFF;
      case (op)
         3'd0: return b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'd1: return b;
         3'd2: return h[15] ? (h | 32'hFFFF_0000) : h;
         3'd3: return h;
         3'd4: return rd;
         default: return 32'd0;
      endcase
   endfunction

   task automatic drive_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
      op_valid_i = 1'b1;
      op_i       = op;
      addr_i     = addr;
      wdata_i    = wd;
   endtask

   // Scoreboard: every done_o pulse must match the oldest queued expectation
   always @(negedge clk) begin
      #2;
      if (done_o === 1'b1) begin
         done_seen++;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL done_unexpected: done_o=1 rdata=%h exc=%b code=%0d with nothing pending",
                     rdata_o, exc_o, exc_code_o);
         end else begin
            mon_e = sb.pop_front();
            if ({rdata_o, exc_o, exc_code_o} !== {mon_e.rdata, mon_e.exc, mon_e.code}) begin
               failures++;
               $display("FAIL done_result: got rdata=%h exc=%b code=%0d, want rdata=%h exc=%b code=%0d",
                        rdata_o, exc_o, exc_code_o, mon_e.rdata, mon_e.exc, mon_e.code);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; op_valid_i = 1'b0; op_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
      flush_i = 1'b0; bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== 70'd0) begin
         failures++;
         $display("FAIL reset_bus: req=%b we=%b addr=%h sel=%b wdata=%h, want all 0",
                  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o);
      end
      checks++;
      if ({stall_o, done_o, rdata_o, exc_o, exc_code_o} !== 40'd0) begin
         failures++;
         $display("FAIL reset_out: stall=%b done=%b rdata=%h exc=%b code=%0d, want all 0",
                  stall_o, done_o, rdata_o, exc_o, exc_code_o);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lb();
      int stalls = 0;
      int d0 = done_seen;
      @(negedge clk);
      drive_op(3'd0, 32'h103, 32'd0);
      bus_rdata_i = 32'h0000_00F0;
      sb.push_back(mk(32'hFFFF_FFF0, 1'b0, 5'd0));
      #1 if (stall_o) stalls++;
      @(negedge clk);
      op_valid_i = 1'b0;
      #1 if (stall_o) stalls++;
      checks++;
      if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o} !== {1'b1, 1'b0, 4'b0001, 32'h100}) begin
         failures++;
         $display("FAIL lb_bus: req=%b we=%b sel=%b addr=%h, want 1 0 0001 00000100",
                  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o);
      end
      @(negedge clk);
      #1 if (stall_o) stalls++;
      @(negedge clk);
      bus_ack_i = 1'b1;
      #1 if (stall_o) stalls++;
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1 if (stall_o) stalls++;
      checks++;
      if (bus_req_o !== 1'b0) begin
         failures++;
         $display("FAIL lb_req_drop: bus_req_o=%b, want 0", bus_req_o);
      end
      @(negedge clk);
      #3 if (stall_o) stalls++;
      checks++;
      if (stalls != 4) begin
         failures++;
         $display("FAIL lb_stall_cycles: got %0d, want 4", stalls);
      end
      checks++;
      if (done_seen - d0 != 1) begin
         failures++;
         $display("FAIL lb_done_count: got %0d, want 1", done_seen - d0);
      end
   endtask

   task automatic test_sh();
      int d0 = done_seen;
      @(negedge clk);
      drive_op(3'd6, 32'h202, 32'h1234_ABCD);
      bus_rdata_i = 32'hDEAD_BEEF;
      sb.push_back(mk(32'd0, 1'b0, 5'd0));
      @(negedge clk);
      op_valid_i = 1'b0;
      bus_ack_i  = 1'b1;
      #1;
      checks++;
      if ({bus_req_o, bus_we_o, bus_sel_o, bus_wdata_o, bus_addr_o} !==
          {1'b1, 1'b1, 4'b0011, 32'hABCD_ABCD, 32'h200}) begin
         failures++;
         $display("FAIL sh_bus: req=%b we=%b sel=%b wdata=%h addr=%h, want 1 1 0011 abcdabcd 00000200",
                  bus_req_o, bus_we_o, bus_sel_o, bus_wdata_o, bus_addr_o);
      end
      @(negedge clk);
      bus_ack_i = 1'b0;
      @(negedge clk);
      #3;
      checks++;
      if (done_seen - d0 != 1) begin
         failures++;
         $display("FAIL sh_done_count: got %0d, want 1", done_seen - d0);
      end
   endtask

   task automatic test_misalign();
      logic [2:0]  ops[4]   = '{3'd4, 3'd7, 3'd2, 3'd6};
      logic [31:0] addrs[4] = '{32'h301, 32'h302, 32'h401, 32'h203};
      logic [4:0]  codes[4] = '{5'd4, 5'd5, 5'd4, 5'd5};
      int d0 = done_seen;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive_op(ops[i], addrs[i], 32'hFFFF_FFFF);
         sb.push_back(mk(32'd0, 1'b1, codes[i]));
         @(negedge clk);
         op_valid_i = 1'b0;
         #1;
         checks++;
         if ({bus_req_o, stall_o} !== 2'b00) begin
            failures++;
            $display("FAIL misalign_nobus[%0d]: req=%b stall=%b, want 0 0", i, bus_req_o, stall_o);
         end
      end
      @(negedge clk);
      #3;
      checks++;
      if (done_seen - d0 != 4) begin
         failures++;
         $display("FAIL misalign_done_count: got %0d, want 4", done_seen - d0);
      end
   endtask

   task automatic test_timeout();
      int reqs = 0;
      int done_at = -1;
      int d0;
      @(negedge clk);
      drive_op(3'd3, 32'h400, 32'd0);
      sb.push_back(mk(32'd0, 1'b1, 5'd7));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         op_valid_i = 1'b0;
         #1;
         if (bus_req_o) reqs++;
         if (done_o && done_at < 0) done_at = i;
      end
      checks++;
      if (reqs != 16) begin
         failures++;
         $display("FAIL timeout_req_cycles: got %0d, want 16", reqs);
      end
      checks++;
      if (done_at != 16) begin
         failures++;
         $display("FAIL timeout_done_cycle: got %0d, want 16", done_at);
      end
      d0 = done_seen;
      @(negedge clk);
      drive_op(3'd4, 32'h404, 32'd0);
      bus_rdata_i = 32'h5555_AAAA;
      sb.push_back(mk(32'd0, 1'b1, 5'd7));
      @(negedge clk);
      op_valid_i = 1'b0;
      bus_ack_i  = 1'b1;
      bus_err_i  = 1'b1;
      @(negedge clk);
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      @(negedge clk);
      #3;
      checks++;
      if (done_seen - d0 != 1) begin
         failures++;
         $display("FAIL ackerr_done_count: got %0d, want 1", done_seen - d0);
      end
   endtask

   task automatic test_flush();
      int d0 = done_seen;
      @(negedge clk);
      drive_op(3'd4, 32'h500, 32'd0);
      flush_i = 1'b1;
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_stall: stall=%b, want 0", stall_o);
      end
      @(negedge clk);
      op_valid_i = 1'b0;
      flush_i    = 1'b0;
      #1;
      checks++;
      if (bus_req_o !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_req: req=%b, want 0", bus_req_o);
      end
      @(negedge clk);
      drive_op(3'd4, 32'h504, 32'd0);
      @(negedge clk);
      op_valid_i = 1'b0;
      @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus_ack_i = 1'b1;
      #1;
      checks++;
      if ({stall_o, bus_req_o} !== 2'b11) begin
         failures++;
         $display("FAIL flush_drain: stall=%b req=%b, want 1 1", stall_o, bus_req_o);
      end
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1;
      checks++;
      if ({stall_o, bus_req_o, done_o} !== 3'b000) begin
         failures++;
         $display("FAIL flush_after_ack: stall=%b req=%b done=%b, want 0 0 0", stall_o, bus_req_o, done_o);
      end
      drive_op(3'd1, 32'h501, 32'd0);
      bus_rdata_i = 32'h00AB_0000;
      sb.push_back(mk(32'h0000_00AB, 1'b0, 5'd0));
      @(negedge clk);
      op_valid_i = 1'b0;
      bus_ack_i  = 1'b1;
      @(negedge clk);
      bus_ack_i = 1'b0;
      @(negedge clk);
      #3;
      checks++;
      if (done_seen - d0 != 1) begin
         failures++;
         $display("FAIL flush_done_count: got %0d, want 1", done_seen - d0);
      end
   endtask

   task automatic test_rst_mid_busy();
      int d0 = done_seen;
      @(negedge clk);
      drive_op(3'd4, 32'h600, 32'd0);
      @(negedge clk);
      op_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      bus_ack_i = 1'b1;
      #1;
      checks++;
      if ({bus_req_o, stall_o, done_o, exc_o} !== 4'b0000) begin
         failures++;
         $display("FAIL rst_busy: req=%b stall=%b done=%b exc=%b, want 0 0 0 0",
                  bus_req_o, stall_o, done_o, exc_o);
      end
      @(negedge clk);
      bus_ack_i = 1'b0;
      @(negedge clk);
      #3;
      checks++;
      if (done_seen != d0) begin
         failures++;
         $display("FAIL rst_busy_done: got %0d pulses, want 0", done_seen - d0);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  op;
      logic [31:0] addr, wd, rd;
      int          dly;
      for (int n = 0; n < 24; n++) begin
         op   = 3'($urandom_range(0, 7));
         addr = 32'h1000 + 32'($urandom_range(0, 63));
         wd   = $urandom;
         rd   = $urandom;
         dly  = $urandom_range(0, 3);
         @(negedge clk);
         drive_op(op, addr, wd);
         bus_rdata_i = rd;
         if (f_misalign(op, addr[1:0]))
            sb.push_back(mk(32'd0, 1'b1, f_store(op) ? 5'd5 : 5'd4));
         else
            sb.push_back(mk(f_load(op, addr[1:0], rd), 1'b0, 5'd0));
         @(negedge clk);
         op_valid_i = 1'b0;
         #1;
         checks++;
         if (f_misalign(op, addr[1:0])) begin
            if (bus_req_o !== 1'b0) begin
               failures++;
               $display("FAIL b2b_misalign_req[%0d]: req=%b, want 0", n, bus_req_o);
            end
         end else begin
            if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o} !==
                {1'b1, f_store(op), f_sel(op, addr[1:0]), addr & 32'hFFFF_FFFC}) begin
               failures++;
               $display("FAIL b2b_bus[%0d]: op=%0d req=%b we=%b sel=%b addr=%h, want 1 %b %b %h",
                        n, op, bus_req_o, bus_we_o, bus_sel_o, bus_addr_o,
                        f_store(op), f_sel(op, addr[1:0]), addr & 32'hFFFF_FFFC);
            end else if (f_store(op) && bus_wdata_o !== f_wdata(op, wd)) begin
               failures++;
               $display("FAIL b2b_wdata[%0d]: got %h, want %h", n, bus_wdata_o, f_wdata(op, wd));
            end
            repeat (dly) @(negedge clk);
            bus_ack_i = 1'b1;
            @(negedge clk);
            bus_ack_i = 1'b0;
         end
      end
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL b2b_pending: %0d results never completed, want 0", sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_misalign();
      test_timeout();
      test_flush();
      test_rst_mid_busy();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width.
REQ-002 Parameter TIMEOUT, default 16: max bus-wait cycles before a bus-error exception; legal range 2..255.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset: synchronous, active-high.
REQ-005 op_valid_i  in  1  memory op present in MEM stage.
REQ-006 op_i  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW.
REQ-007 addr_i  in  ADDR_W  effective byte address.
REQ-008 wdata_i  in  32  store source register value.
REQ-009 flush_i  in  1  pipeline flush (exception/eret) aborting the current op.
REQ-010 bus_req_o, bus_we_o  out  1 each  bus request, write enable.
REQ-011 bus_addr_o  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
REQ-012 bus_sel_o  out  4  byte lanes, big-endian (addr[1:0]=00 -> 4'b1000).
REQ-013 bus_wdata_o  out  32  lane-replicated store data.
REQ-014 bus_ack_i, bus_err_i  in  1 each  transfer complete, bus fault.
REQ-015 bus_rdata_i  in  32  read data, valid with bus_ack_i.
REQ-016 stall_o  out  1  hold upstream pipeline.
REQ-017 done_o  out  1  one-cycle op-complete pulse.
REQ-018 rdata_o  out  32  extended load result, valid with done_o.
REQ-019 exc_o  out  1; exc_code_o  out  5  exception flag and code, valid with done_o.

Function
REQ-020 FSM states IDLE, BUSY, DONE; one op in flight.
REQ-021 IDLE and op_valid_i: latch op, addr, lane data; alignment error (LH/LHU/SH addr[0]!=0, LW/SW addr[1:0]!=0) -> DONE with exc_o=1, code 4 (loads) or 5 (stores), no bus access; else -> BUSY.
REQ-022 BUSY: bus_req_o=1; bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o registered and stable until exit.
REQ-023 Lanes: byte ops one lane per addr[1:0] (00->1000, 01->0100, 10->0010, 11->0001); halfword 00->1100, 10->0011; word 1111.
REQ-024 Store data: SB {4{b[7:0]}}, SH {2{h[15:0]}}, SW word.
REQ-025 Load extract from selected lane(s); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; registered at ack.
REQ-026 BUSY exit priority: bus_err_i -> DONE, exc code 7; else bus_ack_i -> DONE, exc_o=0; else wait counter reaches TIMEOUT-1 -> DONE, exc code 7, bus_req_o drops.
REQ-027 Wait counter cleared on BUSY entry, +1 per BUSY cycle without ack/err; ack on the timeout cycle counts as success.
REQ-028 DONE lasts exactly one cycle: done_o=1, stall_o=0, then IDLE; no op accepted in DONE.
REQ-029 stall_o = (IDLE & op_valid_i & ~flush_i) | BUSY.
REQ-030 flush_i in IDLE: op ignored. flush_i in BUSY: op marked aborted; bus held to ack/err/timeout; then IDLE directly, no done_o; stall_o stays 1 while draining.
REQ-031 flush_i in DONE: done_o forced 0 that cycle.
REQ-032 Outside DONE: rdata_o, exc_o, exc_code_o = 0.

Reset
REQ-033 rst=1 at a clock edge: state IDLE, counter 0, abort flag 0, all outputs 0, even mid-BUSY (an outstanding bus transfer is abandoned).

Verification
REQ-034 LB addr=0x103, bus_rdata_i=0x000000F0, ack 2 cycles after req -> bus_sel_o=0001, bus_addr_o=0x100, rdata_o=0xFFFFFFF0, done_o one cycle, stall_o high for 4 cycles.
REQ-035 SH addr=0x202, wdata_i=0x1234ABCD, ack immediate -> bus_we_o=1, bus_sel_o=0011, bus_wdata_o=0xABCDABCD, exc_o=0.
REQ-036 LW addr=0x301 -> no bus_req_o, next cycle done_o=1, exc_code_o=4; SW addr=0x302 -> exc_code_o=5.
REQ-037 LHU addr=0x400, no ack, TIMEOUT=16 -> bus_req_o high 16 cycles, then done_o=1, exc_code_o=7; repeat with ack and err same cycle -> code 7.
REQ-038 flush_i in 2nd BUSY cycle, ack 3 cycles later -> no done_o, stall_o low after ack cycle, next op accepted normally.
REQ-039 rst mid-BUSY -> next cycle bus_req_o=0, stall_o=0, done_o=0, state IDLE.
